// File: rtl/turn_judge.sv
// turn_judge: referee for one Chicken Cha-Cha-Cha turn.
// Judges card flips against the next track tile, advances chicks,
// requests the turn hand-off and latches the winner.
//
//  state       | meaning
//  ------------+-----------------------------------------------------------
//  S_IDLE      | no game running; waits for start
//  S_WAIT_FLIP | owner may flip a card; timeout counter running
//  S_JUDGE     | compare the registered card image with the next tile
//  S_PASS      | issue the single-cycle next-turn request
//  S_WAIT_TURN | wait for cur_player to move away from the turn owner
//  S_WIN       | game over; winner held until the next start
module turn_judge #(
    parameter int NUM_CARDS = 12,
    parameter int TRACK_LEN = 24,
    parameter int POS_W     = 5,
    parameter int IMG_W     = 4,
    parameter int TIMEOUT   = 1000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             num_players,
    input  logic [1:0]             cur_player,
    input  logic                   start,
    input  logic                   flip_valid,
    input  logic [3:0]             flip_idx,
    input  logic [IMG_W-1:0]       flip_image,
    input  logic [IMG_W-1:0]       tile_image,
    output logic [POS_W-1:0]       tile_addr,
    output logic                   statecombo_next_turn,
    output logic                   hit,
    output logic                   miss,
    output logic                   flip_reject,
    output logic [NUM_CARDS-1:0]   flipped_mask,
    output logic [4*POS_W-1:0]     pos_flat,
    output logic                   winner_valid,
    output logic [1:0]             winner_id
);

    // The turn timer is a down-counter: loaded with TIMEOUT-1 on entry to
    // S_WAIT_FLIP, a flip-less cycle at zero is the timeout.
    localparam int                   TMR_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0]     TMR_LOAD  = TMR_W'(TIMEOUT - 1);
    localparam logic [POS_W-1:0]     POS_LAST  = POS_W'(TRACK_LEN - 1);
    localparam logic [NUM_CARDS-1:0] MASK_FULL = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_FLIP,
        S_JUDGE,
        S_PASS,
        S_WAIT_TURN,
        S_WIN
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           owner_q, owner_d;
    logic [POS_W-1:0]     pos_q [4];
    logic [POS_W-1:0]     pos_d [4];
    logic [NUM_CARDS-1:0] mask_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [IMG_W-1:0]     img_q, img_d;
    logic                 hit_d, miss_d, reject_d, next_turn_d;
    logic                 win_valid_d;
    logic [1:0]           win_id_d;
    logic [POS_W-1:0]     tile_addr_d;

    logic [2:0]           player_cnt;
    logic [1:0]           cur_eff;
    logic                 idx_ok;
    logic [NUM_CARDS-1:0] idx_onehot;
    logic                 flip_accept;
    logic [POS_W-1:0]     owner_next_tile;

    function automatic logic [POS_W-1:0] next_tile(input logic [POS_W-1:0] p);
        return (p == POS_LAST) ? '0 : p + POS_W'(1);
    endfunction

    // An out-of-range turn index from the turn logic falls back to player 0.
    assign player_cnt = (num_players == 2'b11) ? 3'd4 : {1'b0, num_players} + 3'd2;
    assign cur_eff    = ({1'b0, cur_player} < player_cnt) ? cur_player : 2'd0;

    assign idx_ok          = int'(flip_idx) < NUM_CARDS;
    assign idx_onehot      = idx_ok ? (NUM_CARDS'(1) << flip_idx) : '0;
    assign flip_accept     = (state_q == S_WAIT_FLIP) && flip_valid && idx_ok &&
                             ((flipped_mask & idx_onehot) == '0);
    assign owner_next_tile = next_tile(pos_q[owner_q]);

    for (genvar p = 0; p < 4; p++) begin : g_pos_flat
        assign pos_flat[p*POS_W +: POS_W] = pos_q[p];
    end

    // Next-state and next-output decode for the turn sequencer.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        pos_d       = pos_q;
        mask_d      = flipped_mask;
        timer_d     = timer_q;
        img_d       = img_q;
        hit_d       = 1'b0;
        miss_d      = 1'b0;
        next_turn_d = 1'b0;
        win_valid_d = winner_valid;
        win_id_d    = winner_id;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    owner_d = cur_eff;
                    mask_d  = '0;
                    timer_d = TMR_LOAD;
                    state_d = S_WAIT_FLIP;
                end
            end
            S_WAIT_FLIP: begin
                if (flip_accept) begin
                    mask_d  = flipped_mask | idx_onehot;
                    img_d   = flip_image;
                    state_d = S_JUDGE;
                end else if (timer_q == '0) begin
                    miss_d  = 1'b1;
                    state_d = S_PASS;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            S_JUDGE: begin
                if (img_q == tile_image) begin
                    hit_d           = 1'b1;
                    pos_d[owner_q]  = owner_next_tile;
                    // Landing back on tile 0 beats a full mask: the lap is won.
                    if (owner_next_tile == '0) begin
                        win_valid_d = 1'b1;
                        win_id_d    = owner_q;
                        state_d     = S_WIN;
                    end else if (flipped_mask == MASK_FULL) begin
                        state_d = S_PASS;
                    end else begin
                        timer_d = TMR_LOAD;
                        state_d = S_WAIT_FLIP;
                    end
                end else begin
                    miss_d  = 1'b1;
                    state_d = S_PASS;
                end
            end
            S_PASS: begin
                next_turn_d = 1'b1;
                state_d     = S_WAIT_TURN;
            end
            S_WAIT_TURN: begin
                if (cur_eff != owner_q) begin
                    owner_d = cur_eff;
                    mask_d  = '0;
                    timer_d = TMR_LOAD;
                    state_d = S_WAIT_FLIP;
                end
            end
            S_WIN: begin
                if (start) begin
                    for (int p = 0; p < 4; p++) pos_d[p] = '0;
                    win_valid_d = 1'b0;
                    win_id_d    = 2'd0;
                    owner_d     = cur_eff;
                    mask_d      = '0;
                    timer_d     = TMR_LOAD;
                    state_d     = S_WAIT_FLIP;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Any flip that did not start a judgement is reported, whatever the state.
        reject_d    = flip_valid && !flip_accept;
        tile_addr_d = next_tile(pos_d[owner_d]);
    end

    // State, game data and registered pulse/level outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q              <= S_IDLE;
            owner_q              <= 2'd0;
            for (int p = 0; p < 4; p++) pos_q[p] <= '0;
            flipped_mask         <= '0;
            timer_q              <= '0;
            img_q                <= '0;
            hit                  <= 1'b0;
            miss                 <= 1'b0;
            flip_reject          <= 1'b0;
            statecombo_next_turn <= 1'b0;
            winner_valid         <= 1'b0;
            winner_id            <= 2'd0;
            tile_addr            <= '0;
        end else begin
            state_q              <= state_d;
            owner_q              <= owner_d;
            for (int p = 0; p < 4; p++) pos_q[p] <= pos_d[p];
            flipped_mask         <= mask_d;
            timer_q              <= timer_d;
            img_q                <= img_d;
            hit                  <= hit_d;
            miss                 <= miss_d;
            flip_reject          <= reject_d;
            statecombo_next_turn <= next_turn_d;
            winner_valid         <= win_valid_d;
            winner_id            <= win_id_d;
            tile_addr            <= tile_addr_d;
        end
    end

endmodule

// File: tb/tb_turn_judge.sv
// Bench for turn_judge: directed game scenarios plus randomized play,
// all checked every cycle against a turn-level model of the game rules.
module tb_turn_judge;

    localparam int NUM_CARDS = 12;
    localparam int TRACK_LEN = 24;
    localparam int POS_W     = 5;
    localparam int IMG_W     = 4;
    localparam int TIMEOUT   = 1000;

    localparam int PH_IDLE = 0, PH_FLIP = 1, PH_JUDGE = 2, PH_PASS = 3, PH_WAIT = 4, PH_WIN = 5;

    logic                 clk = 1'b0;
    logic                 rst, start, flip_valid;
    logic [1:0]           num_players, cur_player;
    logic [3:0]           flip_idx;
    logic [IMG_W-1:0]     flip_image, tile_image;
    logic [POS_W-1:0]     tile_addr;
    logic                 statecombo_next_turn, hit, miss, flip_reject;
    logic [NUM_CARDS-1:0] flipped_mask;
    logic [4*POS_W-1:0]   pos_flat;
    logic                 winner_valid;
    logic [1:0]           winner_id;

    logic [IMG_W-1:0]     track [TRACK_LEN];

    int n_vec = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    // model of the game
    int                   m_phase, m_owner, m_waited, m_img, m_wid, m_tile;
    int                   m_pos [4];
    bit [NUM_CARDS-1:0]   m_mask;
    bit                   m_hit, m_miss, m_rej, m_nt, m_wv;

    always #5 clk = ~clk;

    assign tile_image = (int'(tile_addr) < TRACK_LEN) ? track[tile_addr] : '0;

    turn_judge #(
        .NUM_CARDS(NUM_CARDS), .TRACK_LEN(TRACK_LEN), .POS_W(POS_W),
        .IMG_W(IMG_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .num_players(num_players), .cur_player(cur_player),
        .start(start), .flip_valid(flip_valid), .flip_idx(flip_idx),
        .flip_image(flip_image), .tile_image(tile_image), .tile_addr(tile_addr),
        .statecombo_next_turn(statecombo_next_turn), .hit(hit), .miss(miss),
        .flip_reject(flip_reject), .flipped_mask(flipped_mask), .pos_flat(pos_flat),
        .winner_valid(winner_valid), .winner_id(winner_id)
    );

    task automatic chk(input string what, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", what, act, exp, $time);
        end
    endtask

    function automatic int nxt(input int p);
        return (p == TRACK_LEN - 1) ? 0 : p + 1;
    endfunction

    function automatic longint model_pos_flat();
        longint v = 0;
        for (int p = 0; p < 4; p++) v = v | (longint'(m_pos[p]) << (p * POS_W));
        return v;
    endfunction

    function automatic int dut_pos(input int p);
        return int'(pos_flat[p*POS_W +: POS_W]);
    endfunction

    task automatic model_step();
        int  cnt, cp, idx, tgt;
        bit  acc;
        if (rst) begin
            m_phase = PH_IDLE; m_owner = 0; m_waited = 0; m_img = 0;
            for (int p = 0; p < 4; p++) m_pos[p] = 0;
            m_mask = '0; m_hit = 0; m_miss = 0; m_rej = 0; m_nt = 0;
            m_wv = 0; m_wid = 0; m_tile = 0;
            return;
        end
        m_hit = 0; m_miss = 0; m_nt = 0; acc = 0;
        cnt = (num_players == 2'b11) ? 4 : int'(num_players) + 2;
        cp  = (int'(cur_player) < cnt) ? int'(cur_player) : 0;
        idx = int'(flip_idx);
        case (m_phase)
            PH_IDLE: if (start) begin
                m_owner = cp; m_mask = '0; m_waited = 0; m_phase = PH_FLIP;
            end
            PH_FLIP: begin
                if (flip_valid && idx < NUM_CARDS && !m_mask[idx]) begin
                    acc = 1; m_mask[idx] = 1'b1; m_img = int'(flip_image); m_phase = PH_JUDGE;
                end else if (m_waited == TIMEOUT - 1) begin
                    m_miss = 1; m_phase = PH_PASS;
                end else begin
                    m_waited++;
                end
            end
            PH_JUDGE: begin
                tgt = nxt(m_pos[m_owner]);
                if (m_img == int'(track[tgt])) begin
                    m_hit = 1; m_pos[m_owner] = tgt;
                    if (tgt == 0) begin
                        m_phase = PH_WIN; m_wv = 1; m_wid = m_owner;
                    end else if (&m_mask) begin
                        m_phase = PH_PASS;
                    end else begin
                        m_phase = PH_FLIP; m_waited = 0;
                    end
                end else begin
                    m_miss = 1; m_phase = PH_PASS;
                end
            end
            PH_PASS: begin
                m_nt = 1; m_phase = PH_WAIT;
            end
            PH_WAIT: if (cp != m_owner) begin
                m_owner = cp; m_mask = '0; m_waited = 0; m_phase = PH_FLIP;
            end
            PH_WIN: if (start) begin
                for (int p = 0; p < 4; p++) m_pos[p] = 0;
                m_wv = 0; m_wid = 0; m_owner = cp; m_mask = '0; m_waited = 0; m_phase = PH_FLIP;
            end
            default: m_phase = PH_IDLE;
        endcase
        m_rej  = flip_valid && !acc;
        m_tile = nxt(m_pos[m_owner]);
    endtask

    // Advance the model on the same edge the DUT samples.
    always @(posedge clk) model_step();

    // Compare every output against the model mid-cycle.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("hit",          longint'(hit),                  longint'(m_hit));
            chk("miss",         longint'(miss),                 longint'(m_miss));
            chk("flip_reject",  longint'(flip_reject),          longint'(m_rej));
            chk("next_turn",    longint'(statecombo_next_turn), longint'(m_nt));
            chk("tile_addr",    longint'(tile_addr),            longint'(m_tile));
            chk("flipped_mask", longint'(flipped_mask),         longint'(m_mask));
            chk("pos_flat",     longint'(pos_flat),             model_pos_flat());
            chk("winner_valid", longint'(winner_valid),         longint'(m_wv));
            chk("winner_id",    longint'(winner_id),            longint'(m_wid));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flip(input int idx, input int img);
        flip_valid = 1'b1;
        flip_idx   = 4'(idx);
        flip_image = IMG_W'(img);
        tick();
        flip_valid = 1'b0;
    endtask

    initial begin
        int n;
        bit seen;
        rst = 1'b1; start = 1'b0; flip_valid = 1'b0; flip_idx = '0; flip_image = '0;
        num_players = 2'b01; cur_player = 2'd0;
        foreach (track[i]) track[i] = IMG_W'(5);

        // reset and start
        tick();
        cmp_en = 1'b1;
        tick();
        chk("t1_pos_flat", longint'(pos_flat), 0);
        chk("t1_tile_rst", longint'(tile_addr), 0);
        chk("t1_outs_rst", longint'({hit, miss, flip_reject, statecombo_next_turn, winner_valid}), 0);
        rst = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_tile_start", longint'(tile_addr), 1);

        // hit
        flip(3, 5); tick();
        chk("t2_hit", longint'(hit), 1);
        chk("t2_pos0", dut_pos(0), 1);
        chk("t2_tile", longint'(tile_addr), 2);
        chk("t2_mask", longint'(flipped_mask), 'h008);
        chk("t2_no_pass", longint'(statecombo_next_turn), 0);

        // miss and pass; flip in WAIT_TURN; hand-off to player 1
        flip(4, 7); tick();
        chk("t3_miss", longint'(miss), 1);
        tick();
        chk("t3_next_turn", longint'(statecombo_next_turn), 1);
        flip(5, 5);
        chk("t4_reject_wait_turn", longint'(flip_reject), 1);
        chk("t3_single_pass", longint'(statecombo_next_turn), 0);
        cur_player = 2'd1; tick();
        chk("t3_mask_clear", longint'(flipped_mask), 0);
        chk("t3_tile_p1", longint'(tile_addr), 1);

        // rejects
        flip(3, 5); tick();
        chk("t4_hit_p1", dut_pos(1), 1);
        flip(3, 5);
        chk("t4_reject_dup", longint'(flip_reject), 1);
        chk("t4_mask_kept", longint'(flipped_mask), 'h008);
        flip(12, 5);
        chk("t4_reject_range", longint'(flip_reject), 1);

        // timeout after exactly TIMEOUT idle cycles
        flip(5, 9); tick(); tick();
        cur_player = 2'd2; tick();
        n = 0;
        for (int k = 1; k <= TIMEOUT + 5; k++) begin
            tick();
            if (miss) begin
                n = k;
                break;
            end
        end
        chk("t5_timeout_cycles", n, TIMEOUT);
        tick();
        chk("t5_timeout_pass", longint'(statecombo_next_turn), 1);

        // a flip in the final cycle is judged instead of timing out
        cur_player = 2'd0; tick();
        seen = 1'b0;
        repeat (TIMEOUT - 1) begin
            tick();
            if (miss) seen = 1'b1;
        end
        flip(0, 5);
        chk("t5_no_early_miss", longint'(seen), 0);
        chk("t5_last_cycle_no_miss", longint'(miss), 0);
        tick();
        chk("t5_last_cycle_hit", longint'(hit), 1);
        chk("t5_pos0", dut_pos(0), 2);

        // player 2 laps the track over two turns
        flip(1, 9); tick(); tick();
        cur_player = 2'd2; tick();
        for (int i = 0; i < 12; i++) begin
            flip(i, 5); tick();
        end
        chk("t6_pos2_12", dut_pos(2), 12);
        chk("t6_mask_full", longint'(flipped_mask), 'hFFF);
        tick();
        chk("t6_full_pass", longint'(statecombo_next_turn), 1);
        cur_player = 2'd0; tick();
        flip(0, 9); tick(); tick();
        cur_player = 2'd2; tick();
        for (int i = 0; i < 11; i++) begin
            flip(i, 5); tick();
        end
        chk("t6_pos2_23", dut_pos(2), 23);
        chk("t6_tile_wrap", longint'(tile_addr), 0);
        flip(11, 5); tick();
        chk("t6_pos2_0", dut_pos(2), 0);
        chk("t6_winner_valid", longint'(winner_valid), 1);
        chk("t6_winner_id", longint'(winner_id), 2);
        flip(2, 5);
        chk("t6_reject_win", longint'(flip_reject), 1);
        start = 1'b1; tick(); start = 1'b0;
        chk("t6_restart_pos", longint'(pos_flat), 0);
        chk("t6_restart_wv", longint'(winner_valid), 0);

        // randomized play for each player count
        foreach (track[i]) track[i] = IMG_W'($urandom_range(0, 3));
        for (int np = 0; np < 4; np++) begin
            num_players = 2'(np);
            rst = 1'b1; tick(); tick(); rst = 1'b0;
            for (int c = 0; c < 5000; c++) begin
                start      = ($urandom_range(0, 19) == 0);
                if ($urandom_range(0, 5) == 0) cur_player = 2'($urandom_range(0, 3));
                flip_valid = ($urandom_range(0, 2) == 0);
                flip_idx   = 4'($urandom_range(0, 13));
                flip_image = ($urandom_range(0, 9) < 7) ? track[m_tile] : IMG_W'($urandom_range(0, 3));
                rst        = ($urandom_range(0, 1999) == 0);
                tick();
            end
        end

        start = 1'b0; flip_valid = 1'b0; rst = 1'b0;
        tick();
        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
